// File: rtl/dot_product_row_feeder_if.sv
// rtl/dot_product_row_feeder_if.sv - upstream and engine-side signals of the dot-product row feeder
interface dot_product_row_feeder_if #(
  parameter int ELEMENT_WIDTH = 32,
  parameter int NO_OF_UNITS   = 8
);
  localparam int PW = ELEMENT_WIDTH * NO_OF_UNITS;

  logic                     start;
  logic [31:0]              start_total;
  logic                     pkg_valid;
  logic                     pkg_ready;
  logic [PW-1:0]            pkg_first;
  logic [PW-1:0]            pkg_second;
  logic                     outsider_read_now;
  logic [PW-1:0]            first_row_input;
  logic [PW-1:0]            second_row_input;
  logic [31:0]              total;
  logic                     finish;
  logic [ELEMENT_WIDTH-1:0] dot_product_output;
  logic [ELEMENT_WIDTH-1:0] result;
  logic                     result_valid;
  logic                     result_ack;
  logic                     busy;
  logic [1:0]               error;

  // The feeder is the initiating end of the row interface.
  modport master (
    input  start, start_total, pkg_valid, pkg_first, pkg_second,
    input  finish, dot_product_output, result_ack,
    output pkg_ready, outsider_read_now, first_row_input, second_row_input,
    output total, result, result_valid, busy, error
  );

  // Upstream sequencer plus engine, as seen from outside the feeder.
  modport slave (
    output start, start_total, pkg_valid, pkg_first, pkg_second,
    output finish, dot_product_output, result_ack,
    input  pkg_ready, outsider_read_now, first_row_input, second_row_input,
    input  total, result, result_valid, busy, error
  );
endinterface

// File: rtl/dot_product_row_feeder.sv
// rtl/dot_product_row_feeder.sv - buffers package pairs and issues them to the dot-product engine
module dot_product_row_feeder #(
  parameter int ELEMENT_WIDTH = 32,
  parameter int NO_OF_UNITS   = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int TIMEOUT       = 1024
) (
  input logic clk,
  input logic reset,
  dot_product_row_feeder_if.master bus
);
  localparam int PW = ELEMENT_WIDTH * NO_OF_UNITS;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [31:0] UNITS = 32'(NO_OF_UNITS);

  typedef enum logic [2:0] {IDLE, ISSUE, HOLD, WAIT_RESULT, DONE} state_t;

  state_t                   state_q;
  logic [PW-1:0]            fifo_first_q  [FIFO_DEPTH];
  logic [PW-1:0]            fifo_second_q [FIFO_DEPTH];
  logic [AW:0]              wr_ptr_q, rd_ptr_q;
  logic [AW:0]              wr_ptr_d, rd_ptr_d;
  logic                     empty, full, push, pop, bad_total;
  logic                     read_now_q;
  logic [PW-1:0]            first_row_q, second_row_q;
  logic [31:0]              total_q, pkg_count_q, issued_q;
  logic                     hold_q;
  logic [TW-1:0]            timer_q;
  logic                     finish_q;
  logic [ELEMENT_WIDTH-1:0] result_q;
  logic                     result_valid_q;
  logic [1:0]               error_q;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign push      = bus.pkg_valid && !full;
  assign pop       = (state_q == ISSUE) && !empty;
  assign wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, push};
  assign rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, pop};
  assign bad_total = (bus.start_total == 32'd0) || ((bus.start_total % UNITS) != 32'd0);

  assign bus.pkg_ready         = !full;
  assign bus.outsider_read_now = read_now_q;
  assign bus.first_row_input   = first_row_q;
  assign bus.second_row_input  = second_row_q;
  assign bus.total             = total_q;
  assign bus.result            = result_q;
  assign bus.result_valid      = result_valid_q;
  assign bus.busy              = (state_q != IDLE);
  assign bus.error             = error_q;

  // Package storage; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_first_q[wr_ptr_q[AW-1:0]]  <= bus.pkg_first;
      fifo_second_q[wr_ptr_q[AW-1:0]] <= bus.pkg_second;
    end
  end

  // FIFO pointers; reset discards whatever was buffered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Sequencer: start check, issue with two-cycle hold, result capture and timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      read_now_q     <= 1'b0;
      first_row_q    <= '0;
      second_row_q   <= '0;
      total_q        <= '0;
      pkg_count_q    <= '0;
      issued_q       <= '0;
      hold_q         <= 1'b0;
      timer_q        <= '0;
      finish_q       <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      error_q        <= 2'b00;
    end else begin
      read_now_q <= 1'b0;
      finish_q   <= bus.finish;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bad_total) begin
              error_q[0] <= 1'b1;
            end else begin
              pkg_count_q <= bus.start_total / UNITS;
              total_q     <= bus.start_total;
              issued_q    <= '0;
              error_q     <= 2'b00;
              state_q     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (pop) begin
            first_row_q  <= fifo_first_q[rd_ptr_q[AW-1:0]];
            second_row_q <= fifo_second_q[rd_ptr_q[AW-1:0]];
            read_now_q   <= 1'b1;
            issued_q     <= issued_q + 32'd1;
            hold_q       <= 1'b0;
            state_q      <= HOLD;
          end
        end
        HOLD: begin
          // Engine reads the upper half one cycle after the pulse, the lower half the cycle after.
          if (!hold_q) begin
            hold_q <= 1'b1;
          end else if (issued_q < pkg_count_q) begin
            state_q <= ISSUE;
          end else begin
            timer_q <= '0;
            state_q <= WAIT_RESULT;
          end
        end
        WAIT_RESULT: begin
          if (bus.finish && !finish_q) begin
            result_q       <= bus.dot_product_output;
            result_valid_q <= 1'b1;
            state_q        <= DONE;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            error_q[1] <= 1'b1;
            state_q    <= IDLE;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        DONE: begin
          if (bus.result_ack) begin
            result_valid_q <= 1'b0;
            state_q        <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dot_product_row_feeder.sv
// tb/tb_dot_product_row_feeder.sv - randomized self-checking bench for dot_product_row_feeder
module tb_dot_product_row_feeder;
  localparam int EW    = 32;
  localparam int NU    = 8;
  localparam int DEPTH = 4;
  localparam int TO    = 1024;
  localparam int PW    = EW * NU;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   total_n = 0;
  int   bad_n   = 0;
  int   pulses_seen = 0;
  int   edge_n = 0;
  bit   chk_on = 1'b0;

  // Behavioural model state: what the outputs must be after the latest rising edge.
  logic [2*PW-1:0] m_q[$];
  bit              m_active, m_rv, m_rn, m_fprev;
  logic [1:0]      m_err;
  logic [31:0]     m_total;
  logic [EW-1:0]   m_result;
  logic [PW-1:0]   m_first, m_second;
  int              m_n, m_issued, m_next, m_wait_from;

  dot_product_row_feeder_if #(.ELEMENT_WIDTH(EW), .NO_OF_UNITS(NU)) ifc();

  dot_product_row_feeder #(
    .ELEMENT_WIDTH(EW), .NO_OF_UNITS(NU), .FIFO_DEPTH(DEPTH), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(ifc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total_n++;
    if (act !== exp) begin
      bad_n++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] rand_pkg();
    logic [PW-1:0] v;
    for (int i = 0; i < NU; i++) v[i*EW +: EW] = $urandom;
    return v;
  endfunction

  // Reference model: FIFO as a queue, issue no earlier than one edge after start and
  // three edges after the previous issue, result wait begins three edges after the last issue.
  initial begin
    int sz;
    logic [2*PW-1:0] pair;
    forever begin
      @(posedge clk);
      edge_n++;
      if (!reset) begin
        m_q.delete();
        m_active = 0; m_rv = 0; m_rn = 0; m_fprev = 0;
        m_err = 2'b00; m_total = '0; m_result = '0;
        m_first = '0; m_second = '0;
        m_n = 0; m_issued = 0; m_next = 0; m_wait_from = 0;
      end else begin
        sz = m_q.size();
        m_rn = 0;
        if (m_active && m_issued < m_n && sz > 0 && edge_n >= m_next) begin
          pair = m_q.pop_front();
          m_first  = pair[2*PW-1:PW];
          m_second = pair[PW-1:0];
          m_rn = 1;
          m_issued++;
          m_next = edge_n + 3;
          if (m_issued == m_n) m_wait_from = edge_n + 3;
        end
        if (ifc.pkg_valid && sz < DEPTH) m_q.push_back({ifc.pkg_first, ifc.pkg_second});
        if (m_rv) begin
          if (ifc.result_ack) begin
            m_rv = 0;
            m_active = 0;
          end
        end else if (m_active && m_issued == m_n && edge_n >= m_wait_from) begin
          if (ifc.finish && !m_fprev) begin
            m_rv = 1;
            m_result = ifc.dot_product_output;
          end else if (edge_n == m_wait_from + TO - 1) begin
            m_err[1] = 1'b1;
            m_active = 0;
          end
        end else if (!m_active && ifc.start) begin
          if (ifc.start_total == 0 || (ifc.start_total % NU) != 0) begin
            m_err[0] = 1'b1;
          end else begin
            m_err = 2'b00;
            m_total = ifc.start_total;
            m_n = int'(ifc.start_total) / NU;
            m_issued = 0;
            m_active = 1;
            m_next = edge_n + 1;
          end
        end
        m_fprev = ifc.finish;
      end
    end
  end

  // Compare process: every falling edge, outputs against the model (or zeros in reset).
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        if (!reset) begin
          chk("rst_read_now", ifc.outsider_read_now, 0);
          chk("rst_first_row", ifc.first_row_input, 0);
          chk("rst_second_row", ifc.second_row_input, 0);
          chk("rst_total", ifc.total, 0);
          chk("rst_result", ifc.result, 0);
          chk("rst_result_valid", ifc.result_valid, 0);
          chk("rst_busy", ifc.busy, 0);
          chk("rst_error", ifc.error, 0);
        end else begin
          chk("pkg_ready", ifc.pkg_ready, m_q.size() < DEPTH);
          chk("read_now", ifc.outsider_read_now, m_rn);
          chk("first_row", ifc.first_row_input, m_first);
          chk("second_row", ifc.second_row_input, m_second);
          chk("total", ifc.total, m_total);
          chk("result", ifc.result, m_result);
          chk("result_valid", ifc.result_valid, m_rv);
          chk("busy", ifc.busy, m_active);
          chk("error", ifc.error, m_err);
        end
      end
      if (ifc.outsider_read_now === 1'b1) pulses_seen++;
    end
  end

  task automatic start_pulse(input int tot);
    ifc.start_total = 32'(tot);
    ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
  endtask

  task automatic push_one();
    bit acc;
    int guard;
    ifc.pkg_first  = rand_pkg();
    ifc.pkg_second = rand_pkg();
    ifc.pkg_valid  = 1'b1;
    acc = 0;
    guard = 0;
    while (!acc && guard < 400) begin
      @(negedge clk);
      acc = ifc.pkg_ready;
      @(posedge clk); #1;
      guard++;
    end
    ifc.pkg_valid = 1'b0;
    chk("push_accepted", acc, 1);
  endtask

  task automatic wait_result(input int n, input int fdly, input logic [EW-1:0] dv,
                             input int adly, input bit early, input bit spur);
    int g;
    bit rv;
    if (spur) begin
      g = 0;
      while (pulses_seen < 1 && g < 400) begin @(posedge clk); #1; g++; end
      ifc.finish = 1'b1;
      repeat (2) @(posedge clk);
      #1 ifc.finish = 1'b0;
    end
    g = 0;
    while (pulses_seen < n && g < 3000) begin @(posedge clk); #1; g++; end
    chk("pulse_count", pulses_seen, n);
    repeat (fdly) @(posedge clk);
    #1;
    ifc.dot_product_output = dv;
    ifc.finish = 1'b1;
    if (early) ifc.result_ack = 1'b1;
    g = 0;
    rv = 0;
    while (!rv && g < 100) begin
      @(negedge clk);
      rv = ifc.result_valid;
      if (!rv) begin @(posedge clk); #1; end
      g++;
    end
    chk("result_valid_seen", rv, 1);
    chk("result_value", ifc.result, dv);
    @(posedge clk); #1;
    if (early) begin
      ifc.result_ack = 1'b0;
    end else begin
      repeat (adly) begin @(posedge clk); #1; end
      ifc.result_ack = 1'b1;
      @(posedge clk); #1;
      ifc.result_ack = 1'b0;
    end
    ifc.finish = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_job(input int tot, input int npush, input int gap, input int fdly,
                         input logic [EW-1:0] dv, input int adly, input bit early, input bit spur);
    pulses_seen = 0;
    start_pulse(tot);
    fork
      begin
        for (int i = 0; i < npush; i++) begin
          push_one();
          repeat (gap) begin @(posedge clk); #1; end
        end
      end
      wait_result(tot / NU, fdly, dv, adly, early, spur);
    join
  endtask

  initial begin
    int g, n, pre;
    bit b;
    ifc.start = 0; ifc.start_total = '0; ifc.pkg_valid = 0;
    ifc.pkg_first = '0; ifc.pkg_second = '0; ifc.finish = 0;
    ifc.dot_product_output = '0; ifc.result_ack = 0;
    repeat (2) @(posedge clk);
    chk_on = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("idle_busy", ifc.busy, 0);
    chk("idle_ready", ifc.pkg_ready, 1);
    @(posedge clk); #1;

    // Basic flow: two packages, engine returns 1.0f.
    run_job(16, 2, 0, 4, 32'h3F800000, 2, 0, 0);
    @(negedge clk);
    chk("basic_total", ifc.total, 32'd16);
    chk("basic_result", ifc.result, 32'h3F800000);
    @(posedge clk); #1;

    // Bad totals leave the feeder idle with error[0]; a good start clears it.
    pulses_seen = 0;
    start_pulse(12);
    @(negedge clk);
    chk("bad12_error", ifc.error, 2'b01);
    chk("bad12_busy", ifc.busy, 0);
    @(posedge clk); #1;
    start_pulse(0);
    repeat (3) @(negedge clk);
    chk("bad0_error", ifc.error, 2'b01);
    chk("bad_no_pulse", pulses_seen, 0);
    @(posedge clk); #1;
    run_job(8, 1, 0, 3, 32'h12345678, 1, 0, 0);
    @(negedge clk);
    chk("good_clears_error", ifc.error, 2'b00);
    @(posedge clk); #1;

    // Starvation with a spurious finish edge while packages trickle in.
    run_job(32, 4, 10, 5, 32'hCAFEF00D, 0, 0, 1);

    // FIFO full before start, fifth pair waits for the first pop.
    for (int i = 0; i < 4; i++) push_one();
    @(negedge clk);
    chk("full_ready_low", ifc.pkg_ready, 0);
    @(posedge clk); #1;
    run_job(40, 1, 0, 6, 32'hA5A5_5A5A, 3, 1, 0);

    // Timeout: one package, no finish.
    start_pulse(8);
    push_one();
    g = 0;
    b = 1;
    while (b && g < TO + 100) begin
      @(negedge clk);
      b = ifc.busy;
      g++;
    end
    chk("timeout_left_busy", b, 0);
    chk("timeout_not_early", g >= TO, 1);
    chk("timeout_error", ifc.error, 2'b10);
    chk("timeout_no_result", ifc.result_valid, 0);
    @(posedge clk); #1;

    // Reset during the hold of the second of four packages.
    for (int i = 0; i < 4; i++) push_one();
    pulses_seen = 0;
    start_pulse(32);
    g = 0;
    while (pulses_seen < 2 && g < 100) begin @(posedge clk); #1; g++; end
    chk("midrst_reached", pulses_seen, 2);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_busy", ifc.busy, 0);
    chk("midrst_rows", ifc.first_row_input, 0);
    chk("midrst_read_now", ifc.outsider_read_now, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    run_job(16, 2, 1, 4, 32'h0BADBEEF, 1, 0, 0);

    // Randomized jobs.
    for (int j = 0; j < 8; j++) begin
      n = $urandom_range(1, 5);
      pre = $urandom_range(0, (n < DEPTH) ? n : DEPTH);
      for (int k = 0; k < pre; k++) push_one();
      run_job(n * NU, n - pre, $urandom_range(0, 6), $urandom_range(3, 8), $urandom,
              $urandom_range(0, 4), 1'($urandom_range(0, 1)), 0);
    end

    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end
endmodule

// File: doc/dot_product_row_feeder.md
Name: dot_product_row_feeder

Overview:
- Initiator end of the dot-product row interface: buffers operand packages from an upstream source and issues them to the eight-unit dot-product engine with the read-now pulse and half-split hold timing that the engine expects.
- Drives the engine's `total`, waits for its `finish` edge, captures the scalar result and returns it upstream with a valid/ack handshake.
- Sits between the matrix-row sequencer and the dot-product engine.

Parameters:
ELEMENT_WIDTH, 32, bits per element
NO_OF_UNITS, 8, elements per package (even, ≥2)
FIFO_DEPTH, 4, package-pair buffer depth (power of 2)
TIMEOUT, 1024, cycles allowed from last issue to finish edge

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse: begin a dot product of start_total elements
start_total  input  32  element count; must be a nonzero multiple of NO_OF_UNITS
pkg_valid  input  1  upstream package pair valid
pkg_ready  output  1  feeder can accept a package pair
pkg_first  input  ELEMENT_WIDTH*NO_OF_UNITS  first-row package
pkg_second  input  ELEMENT_WIDTH*NO_OF_UNITS  second-row package
outsider_read_now  output  1  one-cycle pulse per package issued to engine
first_row_input  output  ELEMENT_WIDTH*NO_OF_UNITS  first-row package to engine
second_row_input  output  ELEMENT_WIDTH*NO_OF_UNITS  second-row package to engine
total  output  32  element count to engine
finish  input  1  engine done (level; rises once per dot product)
dot_product_output  input  ELEMENT_WIDTH  engine result
result  output  ELEMENT_WIDTH  captured result
result_valid  output  1  result held until result_ack
result_ack  input  1  upstream consumes result
busy  output  1  high in every state except IDLE
error  output  2  sticky: bit0 = bad total, bit1 = timeout; cleared by next accepted start

Behaviour:
- Reset (reset=0, async) sets: outputs low/zero, FIFO empty, state IDLE, counters zero, finish edge register zero.
- FIFO:
  - Push when pkg_valid && pkg_ready.
  - pkg_ready = !full; the FIFO accepts pushes in any state.
  - Pop only in ISSUE.
  - Simultaneous push and pop when full is not allowed: pkg_ready is low when full, so no push occurs that cycle.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- IDLE:
  - start with start_total==0 or start_total%NO_OF_UNITS!=0: set error[0], remain IDLE.
  - Valid start: latch pkg_count = start_total/NO_OF_UNITS, drive total=start_total (held until next start), clear error, go ISSUE.
  - start outside IDLE is ignored.
- ISSUE:
  - FIFO empty: wait.
  - FIFO not empty: pop, register the package onto first_row_input/second_row_input, assert outsider_read_now for exactly this one cycle, increment issued, go HOLD.
- HOLD:
  - Row outputs stay stable for 2 further cycles; the engine samples the upper half at +1 and the lower half at +2.
  - Then, if issued<pkg_count, return to ISSUE; else go WAIT_RESULT.
  - Minimum package spacing is therefore 3 cycles; a full FIFO sustains that rate.
  - Row outputs keep their last value after HOLD; they never return to zero.
- WAIT_RESULT:
  - Detect the finish rising edge (finish && !finish_q).
  - On the edge: result<=dot_product_output, result_valid<=1, go DONE.
  - A cycle counter runs in this state. Reaching TIMEOUT sets error[1] and returns to IDLE without asserting result_valid.
- DONE:
  - On result_ack: result_valid<=0, go IDLE.
  - result_ack in the same cycle as the capture is ignored; ack is honoured from the cycle after result_valid rises.
- A finish rising edge outside WAIT_RESULT is ignored and does not set result_valid.
- Reset asserted mid-operation aborts immediately. FIFO contents are discarded, no partial result is produced, and outsider_read_now goes low asynchronously.
- busy=1 in ISSUE/HOLD/WAIT_RESULT/DONE.

Test Plan:
- Basic flow: reset, start_total=16, push 2 package pairs → exactly 2 outsider_read_now pulses ≥3 cycles apart, total=16; engine model raises finish with 0x3F800000 → result=0x3F800000, result_valid until ack.
- Bad total: start_total=12, then start_total=0 → error[0]=1, busy stays 0, no read_now pulse; next start_total=8 clears error.
- Starvation: start_total=32 with packages pushed slowly (one per 10 cycles) → issue waits in ISSUE, 4 pulses total, each data word stable for the 2 hold cycles after its pulse.
- FIFO full: push 5 pairs with FIFO_DEPTH=4 before start → pkg_ready low after 4th push; after start, pointers wrap correctly and packages are issued in push order.
- Timeout: start_total=8, push 1 pair, never raise finish → error[1]=1 after TIMEOUT cycles, state returns to IDLE, result_valid never asserted.
- Reset mid-stream: deassert reset (drive 0) during HOLD of the 2nd of 4 packages → all outputs zero immediately; after release, a new start with fresh packages completes normally.
